mem_access_unit: RTL

MEM-stage access controller. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and drives an external variable-latency data memory through a req/ack handshake. It adds a one-entry posted write buffer so that stores do not stall. It generates the pipeline stall, captures load data, flags illegal accesses, and counts stall cycles.

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// MEM-stage access controller sitting between the EX/MEM and MEM/WB pipeline
// registers. It drives a variable-latency data memory over a req/ack
// handshake, posts stores into a one-entry write buffer so they do not stall
// the pipeline, captures load data, flags misaligned or conflicting accesses
// and keeps a saturating count of stall cycles.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          asynchronous reset, active low
//   mem_read_i     load request from EX/MEM
//   mem_write_i    store request from EX/MEM
//   addr_i         byte address from EX/MEM
//   wdata_i        store data from EX/MEM
//   stall_o        freezes PC, IF/ID, ID/EX and EX/MEM while high
//   rdata_o        data of the last completed load
//   rdata_valid_o  one-cycle pulse in the cycle after a load completes
//   access_err_o   one-cycle pulse after an illegal access is rejected
//   mem_req_o      memory request
//   mem_we_o       1 = write, 0 = read (meaningful while mem_req_o is high)
//   mem_addr_o     memory address (0 while no request)
//   mem_wdata_o    memory write data (0 unless writing)
//   mem_ack_i      memory completion, only looked at while mem_req_o is high
//   mem_rdata_i    memory read data, valid with mem_ack_i on a read
//   stall_cnt_o    saturating count of cycles with stall_o high

module mem_access_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic             stall_o,
  output logic [31:0]      rdata_o,
  output logic             rdata_valid_o,
  output logic             access_err_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DONE  = 2'd2,
    WR_DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;

  logic             any_req;
  logic             misaligned;
  logic             conflict;
  logic             illegal;

  // Request decode. An access is illegal when it is not word aligned or
  // when the instruction claims to be both a load and a store.
  assign any_req    = mem_read_i | mem_write_i;
  assign misaligned = (addr_i[1:0] != 2'b00);
  assign conflict   = mem_read_i & mem_write_i;
  assign illegal    = misaligned | conflict;

  // Next-state and output decode. New accesses are only taken in IDLE, so
  // a load still sitting in EX/MEM during RD_DONE is not accepted twice, and
  // anything arriving while the write buffer drains waits behind it.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = 1'b0;
    stall_o       = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    rdata_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          if (illegal) begin
            err_d = 1'b1;
          end else if (mem_write_i) begin
            // Posted store: the buffer takes it and the pipeline moves on.
            addr_d  = addr_i;
            wdata_d = wdata_i;
            state_d = WR_DRAIN;
          end else begin
            stall_o = 1'b1;
            addr_d  = addr_i;
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i) begin
          rdata_d = mem_rdata_i;
          state_d = RD_DONE;
        end
      end

      RD_DONE: begin
        // The load leaves EX/MEM at this edge; the extra cycle also gives
        // the handshake its mandatory req-low gap.
        rdata_valid_o = 1'b1;
        state_d       = IDLE;
      end

      WR_DRAIN: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        // Hold back any new access until the buffered store has landed so
        // that a following load can never overtake it.
        stall_o   = any_req;
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address and data are only driven while they mean something, which keeps
  // the bus quiet between transactions.
  assign mem_addr_o    = mem_req_o ? addr_q  : 32'd0;
  assign mem_wdata_o   = mem_we_o  ? wdata_q : 32'd0;
  assign rdata_o       = rdata_q;
  assign access_err_o  = err_q;
  assign stall_cnt_o   = cnt_q;

  // State, captured address/data and the registered error pulse. Reset
  // drops straight back to IDLE, abandoning any memory transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Stall-cycle counter; it sticks at all ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (stall_o && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
